// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with a valid/ready handshake,
// synchronous flush and an optional 2-entry skid buffer.
//
// SKID_EN=1: in_ready comes only from registered state (plus reset/flush),
// so downstream backpressure never reaches upstream combinationally. The
// second entry catches the payload that upstream sends in the cycle before
// it sees in_ready fall.
// SKID_EN=0: a single register whose in_ready passes out_ready through, so
// a full stage can still take a new payload in the cycle it hands one on.
//
// reset has priority over flush, and flush over normal operation. Both clear
// the stage to EMPTY and load FLUSH_VAL into every data register.

module pipe_stage_skid #(
    parameter int                 DATA_W    = 96,
    parameter int                 SKID_EN   = 1,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // EMPTY: nothing held. FULL: head in main. SKID: head in main, next in skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_data = main_q;

    generate
        if (SKID_EN != 0) begin : g_skid_ready
            // Ready decodes registered state only; reset and flush block acceptance.
            assign in_ready = !reset && !flush && (state != SKID);
        end else begin : g_pass_ready
            // A full stage may accept when the head leaves in the same cycle.
            assign in_ready = !reset && !flush && (!out_valid || out_ready);
        end
    endgenerate

    // Stage state machine with registered out_valid, occupancy and data.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            main_q    <= FLUSH_VAL;
            skid_q    <= FLUSH_VAL;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else if (SKID_EN != 0) begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= FULL;
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state     <= SKID;
                        skid_q    <= in_data;
                        occupancy <= 2'd2;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state     <= FULL;
                        main_q    <= skid_q;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    occupancy <= 2'd0;
                end
            endcase
        end else begin
            if (in_fire) begin
                state     <= FULL;
                main_q    <= in_data;
                out_valid <= 1'b1;
                occupancy <= 2'd1;
            end else if (out_fire) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                occupancy <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenarios plus a random valid/ready soak for
// both the skid (SKID_EN=1) and pass-through (SKID_EN=0) builds, checked
// against a queue-based reference model.

module tb_pipe_stage_skid;

    localparam int          W  = 32;
    localparam logic [W-1:0] FV = 32'hDEAD_BEEF;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_out_data;
    logic [1:0]   s_occupancy;
    logic         p_in_ready, p_out_valid;
    logic [W-1:0] p_out_data;
    logic [1:0]   p_occupancy;

    int checks;
    int failures;

    pipe_stage_skid #(.DATA_W(W), .SKID_EN(1), .FLUSH_VAL(FV)) dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy)
    );

    pipe_stage_skid #(.DATA_W(W), .SKID_EN(0), .FLUSH_VAL(FV)) dut_pass (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
        .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
        .occupancy(p_occupancy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_skid(input logic [W-1:0] a, input logic [W-1:0] b);
        flush = 0; reset = 0;
        in_valid = 1; in_data = a; out_ready = 1;
        tick();
        out_ready = 0; in_data = b;
        tick();
        in_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; in_valid = 1; in_data = 32'h1234; out_ready = 1;
        #1;
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL reset_s_in_ready: got %0b expected 0", s_in_ready); end
        checks++; if (p_in_ready !== 1'b0) begin failures++; $display("FAIL reset_p_in_ready: got %0b expected 0", p_in_ready); end
        tick(); tick();
        reset = 0; in_valid = 0;
        #1;
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_s_out_valid: got %0b expected 0", s_out_valid); end
        checks++; if (s_occupancy !== 2'd0) begin failures++; $display("FAIL reset_s_occupancy: got %0d expected 0", s_occupancy); end
        checks++; if (s_out_data !== FV) begin failures++; $display("FAIL reset_s_out_data: got %0h expected %0h", s_out_data, FV); end
        checks++; if (p_out_valid !== 1'b0) begin failures++; $display("FAIL reset_p_out_valid: got %0b expected 0", p_out_valid); end
        checks++; if (p_out_data !== FV) begin failures++; $display("FAIL reset_p_out_data: got %0h expected %0h", p_out_data, FV); end
        checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL after_reset_s_in_ready: got %0b expected 1", s_in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1; in_data = i;
            #1;
            checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, s_in_ready); end
            tick();
            checks++; if (s_out_valid !== 1'b1 || s_out_data !== W'(i)) begin failures++; $display("FAIL stream_out[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i, s_out_valid, s_out_data, i); end
            checks++; if (s_occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, s_occupancy); end
        end
        in_valid = 0;
        tick();
        checks++; if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain: got v=%0b occ=%0d expected v=0 occ=0", s_out_valid, s_occupancy); end
    endtask

    task automatic test_skid_backpressure();
        in_valid = 1; in_data = 32'hA; out_ready = 1;
        tick();
        out_ready = 0; in_data = 32'hB;
        #1;
        checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept_b: got %0b expected 1", s_in_ready); end
        tick();
        in_data = 32'hC;
        #1;
        checks++; if (s_occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ2: got %0d expected 2", s_occupancy); end
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low: got %0b expected 0", s_in_ready); end
        checks++; if (s_out_data !== 32'hA) begin failures++; $display("FAIL bp_hold_a: got %0h expected a", s_out_data); end
        tick();
        in_valid = 0;
        checks++; if (s_out_data !== 32'hA || s_occupancy !== 2'd2) begin failures++; $display("FAIL bp_stall_stable: got d=%0h occ=%0d expected d=a occ=2", s_out_data, s_occupancy); end
        out_ready = 1;
        tick();
        checks++; if (s_out_data !== 32'hB || s_occupancy !== 2'd1 || s_out_valid !== 1'b1) begin failures++; $display("FAIL bp_emit_b: got d=%0h occ=%0d v=%0b expected d=b occ=1 v=1", s_out_data, s_occupancy, s_out_valid); end
        tick();
        checks++; if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0) begin failures++; $display("FAIL bp_empty: got v=%0b occ=%0d expected v=0 occ=0", s_out_valid, s_occupancy); end
    endtask

    task automatic test_flush();
        build_skid(32'hA, 32'hB);
        checks++; if (s_occupancy !== 2'd2) begin failures++; $display("FAIL flush_setup_occ: got %0d expected 2", s_occupancy); end
        flush = 1; in_valid = 1; in_data = 32'hC; out_ready = 0;
        #1;
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %0b expected 0", s_in_ready); end
        tick();
        flush = 0; in_valid = 0;
        checks++; if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0) begin failures++; $display("FAIL flush_cleared: got v=%0b occ=%0d expected v=0 occ=0", s_out_valid, s_occupancy); end
        checks++; if (s_out_data !== FV) begin failures++; $display("FAIL flush_data: got %0h expected %0h", s_out_data, FV); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_emit[%0d]: got v=%0b d=%0h expected v=0", i, s_out_valid, s_out_data); end
        end
    endtask

    task automatic test_reset_mid();
        build_skid(32'h21, 32'h22);
        reset = 1;
        #1;
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_ready_during: got %0b expected 0", s_in_ready); end
        tick();
        reset = 0;
        #1;
        checks++; if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0) begin failures++; $display("FAIL rmid_cleared: got v=%0b occ=%0d expected v=0 occ=0", s_out_valid, s_occupancy); end
        checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready_after: got %0b expected 1", s_in_ready); end
    endtask

    task automatic test_passthrough();
        in_valid = 1; in_data = 32'h11; out_ready = 0;
        tick();
        checks++; if (p_out_valid !== 1'b1 || p_out_data !== 32'h11) begin failures++; $display("FAIL pass_first: got v=%0b d=%0h expected v=1 d=11", p_out_valid, p_out_data); end
        out_ready = 1; in_data = 32'h55;
        #1;
        checks++; if (p_in_ready !== 1'b1) begin failures++; $display("FAIL pass_ready_same_cycle: got %0b expected 1", p_in_ready); end
        tick();
        checks++; if (p_out_data !== 32'h55 || p_occupancy !== 2'd1) begin failures++; $display("FAIL pass_next: got d=%0h occ=%0d expected d=55 occ=1", p_out_data, p_occupancy); end
        out_ready = 0; in_data = 32'h66;
        #1;
        checks++; if (p_in_ready !== 1'b0) begin failures++; $display("FAIL pass_ready_low: got %0b expected 0", p_in_ready); end
        tick();
        checks++; if (p_out_data !== 32'h55) begin failures++; $display("FAIL pass_hold: got %0h expected 55", p_out_data); end
        in_valid = 0; out_ready = 1;
        tick();
        checks++; if (p_out_valid !== 1'b0) begin failures++; $display("FAIL pass_drain: got %0b expected 0", p_out_valid); end
    endtask

    task automatic test_random_soak();
        logic [W-1:0] qs[$];
        logic [W-1:0] qp[$];
        logic [W-1:0] s_last, p_last;
        logic         exp_s_ready, exp_p_ready;
        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        tick();
        reset = 0;
        s_last = FV; p_last = FV;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            #1;
            exp_s_ready = !reset && !flush && (qs.size() < 2);
            exp_p_ready = !reset && !flush && (qp.size() == 0 || out_ready);
            checks++; if (s_in_ready !== exp_s_ready) begin failures++; $display("FAIL soak_s_in_ready@%0d: got %0b expected %0b", cyc, s_in_ready, exp_s_ready); end
            checks++; if (p_in_ready !== exp_p_ready) begin failures++; $display("FAIL soak_p_in_ready@%0d: got %0b expected %0b", cyc, p_in_ready, exp_p_ready); end
            checks++; if (s_out_valid !== (qs.size() > 0) || s_occupancy !== 2'(qs.size())) begin failures++; $display("FAIL soak_s_state@%0d: got v=%0b occ=%0d expected occ=%0d", cyc, s_out_valid, s_occupancy, qs.size()); end
            checks++; if (p_out_valid !== (qp.size() > 0) || p_occupancy !== 2'(qp.size())) begin failures++; $display("FAIL soak_p_state@%0d: got v=%0b occ=%0d expected occ=%0d", cyc, p_out_valid, p_occupancy, qp.size()); end
            checks++; if (s_out_data !== (qs.size() > 0 ? qs[0] : s_last)) begin failures++; $display("FAIL soak_s_data@%0d: got %0h expected %0h", cyc, s_out_data, (qs.size() > 0 ? qs[0] : s_last)); end
            checks++; if (p_out_data !== (qp.size() > 0 ? qp[0] : p_last)) begin failures++; $display("FAIL soak_p_data@%0d: got %0h expected %0h", cyc, p_out_data, (qp.size() > 0 ? qp[0] : p_last)); end
            if (reset || flush) begin
                qs.delete(); qp.delete();
                s_last = FV; p_last = FV;
            end else begin
                if (out_ready && qs.size() > 0) void'(qs.pop_front());
                if (exp_s_ready && in_valid) qs.push_back(in_data);
                if (out_ready && qp.size() > 0) void'(qp.pop_front());
                if (exp_p_ready && in_valid) qp.push_back(in_data);
                if (qs.size() > 0) s_last = qs[0];
                if (qp.size() > 0) p_last = qp[0];
            end
            tick();
        end
        reset = 0; flush = 0; in_valid = 0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks = 0; failures = 0;
        reset = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        test_reset();
        test_stream();
        test_skid_backpressure();
        test_flush();
        test_reset_mid();
        test_passthrough();
        test_random_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
